mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
//   Parametrised memory-access (MM) pipeline stage for the 16-bit CPU datapath.
//   Sits between EX and WB. Holds a DEPTH-word data memory and performs stores
//   or loads per op. Drives WB with the ALU result or the loaded word.
//   Adds a valid/ready handshake on both sides, configurable load wait states,
//   output backpressure and a reset.
// PARAMETERS
//   DATA_W   16  data/ALU word width (bits)
//   ADDR_W   4   memory address width; DEPTH = 2**ADDR_W words
//   RD_WAIT  0   extra wait cycles per load, legal 0..15 (elaboration error otherwise)
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        EX presents an op
//   in_ready   out  1        stage accepts op this cycle
//   alu_in     in   DATA_W   ALU result; address = alu_in[ADDR_W-1:0]
//   wd         in   DATA_W   store data
//   we         in   1        op is a store
//   mr         in   1        op is a load (memory-to-register select)
//   out_valid  out  1        result beat valid to WB
//   out_ready  in   1        WB accepts beat
//   out_data   out  DATA_W   result: mem word (load) else alu_in
//   busy       out  1        high while in WAIT state
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, wait cnt=0, out_valid=0,
//     out_data=0, busy=0. in_ready=0 while rst_n low. Memory array not reset.
//   - Accept = in_valid & in_ready (sampled at rising clk). out_free = !out_valid | out_ready.
//   - in_ready = (state==IDLE) & out_free & rst_n.
//   - Address bits above ADDR_W-1 are ignored for both reads and writes.
//   - Op classes on accept:
//     store (we=1, mr ignored): mem[addr]<=wd at accept edge; out_data<=alu_in,
//       out_valid<=1 at the same edge.
//     pass  (we=0, mr=0): out_data<=alu_in, out_valid<=1 at accept edge.
//     load  (we=0, mr=1): mem[addr] captured into rd_buf at accept edge.
//       RD_WAIT=0: out_data<=mem[addr], out_valid<=1 at accept edge.
//       RD_WAIT>0: state<=WAIT, cnt<=RD_WAIT.
//   - Latency (accept edge to out_valid high): 1 cycle for store/pass/load
//     with RD_WAIT=0; 1+RD_WAIT cycles for load if WB is not stalling.
//   - FSM: IDLE --load & RD_WAIT>0--> WAIT.
//     WAIT: cnt decrements each edge while cnt>1. When cnt==1 and out_free:
//     out_data<=rd_buf, out_valid<=1, state<=IDLE. If !out_free, stay in WAIT
//     with cnt held at 1. busy=1 and in_ready=0 throughout WAIT.
//   - Output hold: out_valid & !out_ready -> out_data and out_valid frozen.
//   - Beat drop: out_valid clears on out_ready unless a new beat loads that edge.
//   - Throughput: 1 op/cycle for store/pass, and for loads when RD_WAIT=0.
//   - Store-then-load to the same address: the load sees the new data because
//     the store commits at its own accept edge.
//   - Read-during-write hazard: impossible, since only one op is accepted per cycle.
//   - Reset mid-WAIT: the pending load is discarded and no beat is emitted.
//     Stores already committed persist in memory.
//   - Exactly one output beat per accepted op, in order.
// TESTING
//   1 Reset: rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, busy=0;
//     release -> in_ready=1.
//   2 RD_WAIT=2: store alu_in=0x0003 wd=0xBEEF, then load alu_in=0x0013 mr=1
//     -> busy=1 and in_ready=0 for 2 cycles; out_valid 3 cycles after accept;
//     out_data=0xBEEF (upper address bits ignored).
//   3 RD_WAIT=0, out_ready=1: pass 0x0001..0x0004 back-to-back -> one beat per
//     cycle, out_data 0x0001..0x0004 in order, in_ready stays 1.
//   4 Backpressure: beat 0x1234 valid, hold out_ready=0 for 4 cycles -> out_data
//     stable at 0x1234, in_ready=0; raise out_ready -> next op accepted that cycle.
//   5 RD_WAIT=3: issue load, assert rst_n=0 at cycle 2 of WAIT -> no beat emitted,
//     state=IDLE; reload same address -> prior stored value returned.
//   6 we=1 and mr=1, alu_in=0x0005 wd=0x00AA -> out_data=0x0005 (treated as store);
//     later load addr 5 -> 0x00AA.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake bundle between EX, the MM stage and WB.
// The stage itself uses the slave modport.
interface mem_stage_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic              mr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport master (
        output in_valid, alu_in, wd, we, mr, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, alu_in, wd, we, mr, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mem_stage_pipe.sv
// Memory-access stage: DEPTH-word data memory, stores/loads/pass-through,
// valid/ready on both sides, optional load wait states.
module mem_stage_pipe #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int RD_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    if (RD_WAIT < 0 || RD_WAIT > 15) begin : g_rd_wait_chk
        $error("mem_stage_pipe: RD_WAIT must be within 0..15");
    end

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } st_t;

    logic [DATA_W-1:0] mem [DEPTH];

    st_t               state;
    st_t               state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    logic              out_free;
    logic              in_ready_c;
    logic              acc;
    logic              is_st;
    logic              is_ld;
    logic              wait_done;
    logic              beat_new;
    logic [DATA_W-1:0] beat_data;

    // Upper address bits are simply not decoded.
    assign addr     = bus.alu_in[ADDR_W-1:0];
    assign rdata    = mem[addr];
    assign out_free = !out_valid_q || bus.out_ready;
    assign acc      = bus.in_valid && in_ready_c;
    assign is_st    = bus.we;
    assign is_ld    = !bus.we && bus.mr;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // State and wait counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: loads with wait states park in WAIT until the count expires
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (acc && is_ld && RD_WAIT > 0) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 4'(RD_WAIT);
                end
            end
            S_WAIT: begin
                if (cnt > 4'd1) begin
                    cnt_nx = cnt - 4'd1;
                end else if (out_free) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Handshake, busy flag and selection of the next output beat
    always_comb begin
        in_ready_c = (state == S_IDLE) && out_free && rst_n;
        bus.busy   = (state == S_WAIT);
        wait_done  = (state == S_WAIT) && (cnt == 4'd1) && out_free;
        beat_new   = wait_done || (acc && (!is_ld || RD_WAIT == 0));
        beat_data  = bus.alu_in;
        unique case (1'b1)
            wait_done:   beat_data = rd_buf;
            acc & is_ld: beat_data = rdata;
            default:     beat_data = bus.alu_in;
        endcase
    end

    // Stores commit at their own accept edge; array has no reset
    always_ff @(posedge clk) begin
        if (acc && is_st) begin
            mem[addr] <= bus.wd;
        end
    end

    // Load word captured at accept, replayed once the wait expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_buf <= '0;
        end else if (acc && is_ld) begin
            rd_buf <= rdata;
        end
    end

    // Output register: load a new beat, hold under stall, drop when taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (beat_new) begin
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: three instances (RD_WAIT 0/2/3) on shared inputs,
// directed vectors and sequences plus a transaction-level scoreboard.
module tb_mem_stage_pipe;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        we;
    logic        mr;
    logic        out_ready;
    logic [15:0] alu_in;
    logic [15:0] wd;

    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  bz;
    logic [15:0] od [3];

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_if #(.DATA_W(16)) if0 ();
    mem_stage_if #(.DATA_W(16)) if2 ();
    mem_stage_if #(.DATA_W(16)) if3 ();

    assign if0.in_valid  = in_valid;
    assign if0.alu_in    = alu_in;
    assign if0.wd        = wd;
    assign if0.we        = we;
    assign if0.mr        = mr;
    assign if0.out_ready = out_ready;
    assign if2.in_valid  = in_valid;
    assign if2.alu_in    = alu_in;
    assign if2.wd        = wd;
    assign if2.we        = we;
    assign if2.mr        = mr;
    assign if2.out_ready = out_ready;
    assign if3.in_valid  = in_valid;
    assign if3.alu_in    = alu_in;
    assign if3.wd        = wd;
    assign if3.we        = we;
    assign if3.mr        = mr;
    assign if3.out_ready = out_ready;

    assign ir    = {if3.in_ready, if2.in_ready, if0.in_ready};
    assign ov    = {if3.out_valid, if2.out_valid, if0.out_valid};
    assign bz    = {if3.busy, if2.busy, if0.busy};
    assign od[0] = if0.out_data;
    assign od[1] = if2.out_data;
    assign od[2] = if3.out_data;

    mem_stage_pipe #(.DATA_W(16), .ADDR_W(4), .RD_WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    mem_stage_pipe #(.DATA_W(16), .ADDR_W(4), .RD_WAIT(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );
    mem_stage_pipe #(.DATA_W(16), .ADDR_W(4), .RD_WAIT(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: memory image and in-order queue of expected beats per DUT.
    logic [15:0] mm    [3][16];
    bit          mk    [3][16];
    logic [15:0] q_d   [3][64];
    bit          q_k   [3][64];
    int          hd    [3];
    int          tl    [3];
    bit          held  [3];
    logic [15:0] hdata [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            hd[k] = 0;
            tl[k] = 0;
            held[k] = 0;
            hdata[k] = '0;
            for (int a = 0; a < 16; a++) begin
                mk[k][a] = 0;
                mm[k][a] = '0;
            end
        end
    end

    // Inputs change just after the rising edge, so at the falling edge both
    // DUT outputs and the inputs for the coming edge are stable.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                hd[k] = tl[k];
                held[k] = 0;
            end else begin
                if (held[k]) begin
                    chk("hold_valid", 32'(ov[k]), 32'd1);
                    chk("hold_data", 32'(od[k]), 32'(hdata[k]));
                end
                if (ov[k] && out_ready) begin
                    chk("beat_expected", 32'(tl[k] > hd[k]), 32'd1);
                    if (tl[k] > hd[k]) begin
                        if (q_k[k][hd[k] % 64])
                            chk("beat_data", 32'(od[k]), 32'(q_d[k][hd[k] % 64]));
                        hd[k]++;
                    end
                end
                held[k] = ov[k] && !out_ready;
                hdata[k] = od[k];
                if (in_valid && ir[k]) begin
                    if (we) begin
                        q_d[k][tl[k] % 64] = alu_in;
                        q_k[k][tl[k] % 64] = 1;
                        mm[k][alu_in[3:0]] = wd;
                        mk[k][alu_in[3:0]] = 1;
                    end else if (mr) begin
                        q_d[k][tl[k] % 64] = mm[k][alu_in[3:0]];
                        q_k[k][tl[k] % 64] = mk[k][alu_in[3:0]];
                    end else begin
                        q_d[k][tl[k] % 64] = alu_in;
                        q_k[k][tl[k] % 64] = 1;
                    end
                    tl[k]++;
                end
            end
        end
    end

    typedef struct {
        logic        iv;
        logic        we;
        logic        mr;
        logic [15:0] alu;
        logic [15:0] wd;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        c_od;
    } vec_t;

    function automatic vec_t mkv(logic iv, logic w, logic m, logic [15:0] a,
                                 logic [15:0] d, logic o, logic er,
                                 logic eo, logic [15:0] ed, logic c);
        vec_t v;
        v.iv = iv; v.we = w; v.mr = m; v.alu = a; v.wd = d; v.ordy = o;
        v.e_rdy = er; v.e_ov = eo; v.e_od = ed; v.c_od = c;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid = 0;
        we = 0;
        mr = 0;
        out_ready = 1;
        repeat (n) step();
    endtask

    vec_t vt [15];
    int   beats;
    int   lat;
    bit   got;

    initial begin
        in_valid = 1; we = 0; mr = 0; alu_in = '0; wd = '0;
        out_ready = 1; rst_n = 0;

        vt[0]  = mkv(1, 0, 0, 16'h0001, 16'h0000, 1, 1, 1, 16'h0001, 1);
        vt[1]  = mkv(1, 0, 0, 16'h0002, 16'h0000, 1, 1, 1, 16'h0002, 1);
        vt[2]  = mkv(1, 0, 0, 16'h0003, 16'h0000, 1, 1, 1, 16'h0003, 1);
        vt[3]  = mkv(1, 0, 0, 16'h0004, 16'h0000, 1, 1, 1, 16'h0004, 1);
        vt[4]  = mkv(1, 1, 1, 16'h0005, 16'h00AA, 1, 1, 1, 16'h0005, 1);
        vt[5]  = mkv(1, 0, 1, 16'h0005, 16'h0000, 1, 1, 1, 16'h00AA, 1);
        vt[6]  = mkv(1, 1, 0, 16'h0003, 16'hBEEF, 1, 1, 1, 16'h0003, 1);
        vt[7]  = mkv(1, 0, 1, 16'h0013, 16'h0000, 1, 1, 1, 16'hBEEF, 1);
        vt[8]  = mkv(1, 0, 0, 16'h1234, 16'h0000, 1, 1, 1, 16'h1234, 1);
        vt[9]  = mkv(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 1);
        vt[10] = mkv(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 1);
        vt[11] = mkv(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 1);
        vt[12] = mkv(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 1);
        vt[13] = mkv(1, 0, 0, 16'h0777, 16'h0000, 1, 1, 1, 16'h0777, 1);
        vt[14] = mkv(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);

        // Reset with in_valid held high
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 32'(ir[k]), 32'd0);
            chk("rst_out_valid", 32'(ov[k]), 32'd0);
            chk("rst_out_data", 32'(od[k]), 32'd0);
            chk("rst_busy", 32'(bz[k]), 32'd0);
        end
        in_valid = 0;
        rst_n = 1;
        #1;
        for (int k = 0; k < 3; k++)
            chk("rel_in_ready", 32'(ir[k]), 32'd1);
        step();

        // Vector table against the zero-wait instance
        for (int i = 0; i < 15; i++) begin
            in_valid = vt[i].iv; we = vt[i].we; mr = vt[i].mr;
            alu_in = vt[i].alu; wd = vt[i].wd; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d_rdy", i), 32'(ir[0]), 32'(vt[i].e_rdy));
            step();
            chk($sformatf("vec%0d_ov", i), 32'(ov[0]), 32'(vt[i].e_ov));
            if (vt[i].c_od)
                chk($sformatf("vec%0d_od", i), 32'(od[0]), 32'(vt[i].e_od));
        end
        drain(8);

        // Two wait states: store then aliased load
        in_valid = 1; we = 1; mr = 0; alu_in = 16'h0003; wd = 16'hBEEF;
        step();
        we = 0; mr = 1; alu_in = 16'h0013;
        #1;
        chk("w2_accept_rdy", 32'(ir[1]), 32'd1);
        step();
        in_valid = 0; mr = 0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("w2_busy_c%0d", c), 32'(bz[1]), 32'(c < 3));
            chk($sformatf("w2_rdy_c%0d", c), 32'(ir[1]), 32'(c == 3));
            chk($sformatf("w2_ov_c%0d", c), 32'(ov[1]), 32'(c == 3));
            if (c < 3) step();
        end
        chk("w2_data", 32'(od[1]), 32'hBEEF);
        drain(8);

        // Three wait states, reset in the second WAIT cycle
        in_valid = 1; we = 1; mr = 0; alu_in = 16'h0007; wd = 16'h5A5A;
        step();
        we = 0; mr = 1;
        #1;
        chk("w3_accept_rdy", 32'(ir[2]), 32'd1);
        step();
        in_valid = 0; mr = 0;
        chk("w3_busy1", 32'(bz[2]), 32'd1);
        step();
        chk("w3_busy2", 32'(bz[2]), 32'd1);
        rst_n = 0;
        #1;
        chk("w3_rst_busy", 32'(bz[2]), 32'd0);
        chk("w3_rst_ov", 32'(ov[2]), 32'd0);
        chk("w3_rst_rdy", 32'(ir[2]), 32'd0);
        step();
        rst_n = 1;
        beats = 0;
        for (int c = 0; c < 6; c++) begin
            if (ov[2]) beats++;
            step();
        end
        chk("w3_no_beat", 32'(beats), 32'd0);
        in_valid = 1; mr = 1; alu_in = 16'h0007;
        #1;
        chk("w3_reload_rdy", 32'(ir[2]), 32'd1);
        step();
        in_valid = 0; mr = 0;
        got = 0;
        lat = -1;
        for (int c = 0; c < 12; c++) begin
            if (ov[2]) begin
                got = 1;
                lat = c;
                break;
            end
            step();
        end
        chk("w3_reload_got", 32'(got), 32'd1);
        chk("w3_reload_lat", 32'(lat), 32'd3);
        chk("w3_reload_data", 32'(od[2]), 32'h5A5A);
        drain(8);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            we        = ($urandom_range(0, 3) == 0);
            mr        = 1'($urandom_range(0, 1));
            alu_in    = 16'($urandom);
            wd        = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 75);
            if (i == 300) rst_n = 0;
            if (i == 302) rst_n = 1;
            step();
        end
        drain(12);
        for (int k = 0; k < 3; k++)
            chk("drain_empty", 32'(tl[k] - hd[k]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
